// File: rtl/mib_train_gen_if.sv
// Control and bus interface of the MIB training-pattern generator.
// The i_inject input exists only when MIB_TRAIN_ERRINJ_EN is defined.
interface mib_train_gen_if #(
   parameter int DATA_W   = 13,
   parameter int REPEAT_W = 8
);
   logic                i_en;
   logic                i_start;
   logic                i_stop;
   logic [1:0]          i_mode;
   logic [REPEAT_W-1:0] i_repeat;
`ifdef MIB_TRAIN_ERRINJ_EN
   logic                i_inject;
`endif
   logic [DATA_W-1:0]   o_data;
   logic                o_strobe;
   logic                o_frame;
   logic                o_busy;
   logic                o_done;

   modport master (
`ifdef MIB_TRAIN_ERRINJ_EN
      output i_inject,
`endif
      output i_en, i_start, i_stop, i_mode, i_repeat,
      input  o_data, o_strobe, o_frame, o_busy, o_done
   );

   modport slave (
`ifdef MIB_TRAIN_ERRINJ_EN
      input  i_inject,
`endif
      input  i_en, i_start, i_stop, i_mode, i_repeat,
      output o_data, o_strobe, o_frame, o_busy, o_done
   );
endinterface

// File: rtl/mib_train_gen.sv
// MIB bus training-pattern generator: fixed / walking-one / PRBS7 words with strobe and frame.
// Defining MIB_TRAIN_ERRINJ_EN adds single-shot bit-0 error injection via i_inject.
module mib_train_gen #(
   parameter int DATA_W   = 13,
   parameter int REPEAT_W = 8
) (
   input logic            i_clk,
   input logic            i_rst_n,
   mib_train_gen_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   localparam logic [6:0] LFSR_SEED = 7'h7F;
   localparam logic [6:0] FIXED_LEN = 7'd7;
   localparam logic [6:0] WALK_LEN  = 7'(DATA_W);
   localparam logic [6:0] PRBS_LEN  = 7'd127;

   function automatic logic [6:0] seq_len(input logic [1:0] mode);
      case (mode)
         2'd1:    return WALK_LEN;
         2'd2:    return PRBS_LEN;
         default: return FIXED_LEN;
      endcase
   endfunction

   // Word idx of the selected sequence; PRBS words replicate the 7-bit LFSR state from the LSB.
   function automatic logic [DATA_W-1:0] pattern_word(input logic [1:0] mode,
                                                      input logic [6:0] idx,
                                                      input logic [6:0] lfsr);
      logic [DATA_W-1:0] w;
      logic [7:0]        tail;
      w    = '0;
      tail = 8'hF5;
      case (mode)
         2'd1: w = {{(DATA_W-1){1'b0}}, 1'b1} << idx;
         2'd2: for (int i = 0; i < DATA_W; i++) w[i] = lfsr[3'(i % 7)];
         default:
            for (int i = 0; i < DATA_W; i++) begin
               case (idx)
                  7'd0:    w[i] = (i % 2) == 1;
                  7'd1:    w[i] = (i % 2) == 0;
                  7'd2:    w[i] = (i % 8) < 4;
                  7'd3:    w[i] = (i % 8) >= 4;
                  7'd4:    w[i] = 1'b0;
                  7'd5:    w[i] = 1'b1;
                  default: w[i] = (i < 8) && tail[3'(i % 8)];
               endcase
            end
      endcase
      return w;
   endfunction

   state_t              state_q, state_d;
   logic [1:0]          mode_q, mode_d;
   logic [REPEAT_W-1:0] repeat_q, repeat_d;
   logic [REPEAT_W-1:0] cnt_q, cnt_d, cnt_next;
   logic [6:0]          idx_q, idx_d;
   logic [6:0]          lfsr_q, lfsr_d, lfsr_next;
   logic                stop_q, stop_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                strobe_q, strobe_d;
   logic                frame_q, frame_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                inj_bit;
   logic [DATA_W-1:0]   flip;
   logic                last_word;
   logic                stop_eff;
   logic                finish_run;

   assign lfsr_next  = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
   assign cnt_next   = cnt_q + REPEAT_W'(1);
   assign last_word  = idx_q == (seq_len(mode_q) - 7'd1);
   assign stop_eff   = stop_q | bus.i_stop;
   assign finish_run = stop_eff || ((repeat_q != '0) && (cnt_next == repeat_q));
   assign flip       = {{(DATA_W-1){1'b0}}, inj_bit};

   always_comb begin
      // NOTE: every target gets a default first, so no path can leave one unassigned and infer a latch.
      state_d  = state_q;
      mode_d   = mode_q;
      repeat_d = repeat_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      lfsr_d   = lfsr_q;
      stop_d   = stop_q;
      data_d   = data_q;
      strobe_d = strobe_q;
      frame_d  = frame_q;
      busy_d   = busy_q;
      done_d   = done_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.i_en && bus.i_start) begin
               state_d  = ST_RUN;
               mode_d   = bus.i_mode;
               repeat_d = bus.i_repeat;
               stop_d   = bus.i_stop;
               cnt_d    = '0;
               idx_d    = '0;
               lfsr_d   = LFSR_SEED;
               data_d   = pattern_word(bus.i_mode, 7'd0, LFSR_SEED) ^ flip;
               strobe_d = ~strobe_q;
               frame_d  = 1'b1;
               busy_d   = 1'b1;
               done_d   = 1'b0;
            end
         end

         ST_RUN: begin
            stop_d = stop_eff;
            if (!bus.i_en) begin
               frame_d = 1'b0;
            end else if (last_word) begin
               cnt_d = cnt_next;
               if (finish_run) begin
                  state_d = ST_DONE;
                  data_d  = '0;
                  frame_d = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  // A full PRBS7 period returns to the seed, so reloading keeps every sequence identical.
                  idx_d    = '0;
                  lfsr_d   = LFSR_SEED;
                  data_d   = pattern_word(mode_q, 7'd0, LFSR_SEED) ^ flip;
                  strobe_d = ~strobe_q;
                  frame_d  = 1'b1;
               end
            end else begin
               idx_d    = idx_q + 7'd1;
               lfsr_d   = lfsr_next;
               data_d   = pattern_word(mode_q, idx_q + 7'd1, lfsr_next) ^ flip;
               strobe_d = ~strobe_q;
               frame_d  = 1'b0;
            end
         end

         ST_DONE: begin
            if (bus.i_en) begin
               state_d = ST_IDLE;
               done_d  = 1'b0;
               stop_d  = 1'b0;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= ST_IDLE;
         mode_q   <= '0;
         repeat_q <= '0;
         cnt_q    <= '0;
         idx_q    <= '0;
         lfsr_q   <= LFSR_SEED;
         stop_q   <= 1'b0;
         data_q   <= '0;
         strobe_q <= 1'b0;
         frame_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking updates so every register samples the pre-edge values.
         state_q  <= state_d;
         mode_q   <= mode_d;
         repeat_q <= repeat_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         lfsr_q   <= lfsr_d;
         stop_q   <= stop_d;
         data_q   <= data_d;
         strobe_q <= strobe_d;
         frame_q  <= frame_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

`ifdef MIB_TRAIN_ERRINJ_EN
   logic inj_q, inj_d, word_load;

   assign inj_bit   = inj_q | bus.i_inject;
   assign word_load = bus.i_en && (((state_q == ST_IDLE) && bus.i_start) ||
                                   ((state_q == ST_RUN) && (state_d == ST_RUN)));

   // Pulses merge into one armed flag that is spent on the next word loaded.
   always_comb begin
      inj_d = inj_bit;
      if (word_load || ((state_q == ST_RUN) && (state_d != ST_RUN))) inj_d = 1'b0;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) inj_q <= 1'b0;
      else          inj_q <= inj_d;
   end
`else
   assign inj_bit = 1'b0;
`endif

   assign bus.o_data   = data_q;
   assign bus.o_strobe = strobe_q;
   assign bus.o_frame  = frame_q;
   assign bus.o_busy   = busy_q;
   assign bus.o_done   = done_q;

endmodule

// File: doc/mib_train_gen.md
Name: mib_train_gen

Overview:
- Parametrised training-pattern generator for the MIB parallel address/data bus.
- Drives a DATA_W-bit word every enabled cycle, plus a toggling strobe and a frame marker, so the receiver can align bus timing.
- Three selectable pattern modes and a programmable repeat count, with a start/stop/busy/done handshake to the bring-up controller.
- Sits on the bus-clock side of the system PLL; i_en is normally tied to PLL lock.

Parameters:
- DATA_W, 13, bus width in bits (range 4..32).
- REPEAT_W, 8, width of the repeat-count input.

Ports:
- i_clk  input  1  bus clock
- i_rst_n  input  1  asynchronous active-low reset
- i_en  input  1  advance qualifier; when low, all state and outputs hold
- i_start  input  1  start pulse, accepted only in IDLE
- i_stop  input  1  request stop at end of current sequence
- i_mode  input  2  pattern mode, latched at start
- i_repeat  input  REPEAT_W  sequences to send, latched at start; 0 = continuous
- o_data  output  DATA_W  registered training word
- o_strobe  output  1  toggles once per word sent
- o_frame  output  1  high with the first word of each sequence
- o_busy  output  1  high in RUN
- o_done  output  1  single-cycle pulse when the run completes

Behaviour:
- Reset: o_data=0, o_strobe=0, o_frame=0, o_busy=0, o_done=0, state IDLE, counters 0, LFSR=7'h7F.
- States: IDLE, RUN, DONE.
- IDLE -> RUN when i_start=1 and i_en=1. i_mode and i_repeat are latched in that cycle.
- First word appears on o_data on the next clock edge (latency 1), with o_frame=1 and o_busy=1.
- RUN, i_en=1: one word per clock. o_strobe inverts with each word. Index advances.
- RUN, i_en=0: o_data, o_strobe, index and LFSR hold. o_frame is forced low. i_stop is still captured.
- Word table by mode:
  - Mode 0 (fixed), 7 words, bits indexed from LSB:
    - P0: bit i = i mod 2, which is 0x0AAA at width 13.
    - P1 = ~P0, which is 0x1555.
    - P2: bit i = 1 when (i mod 8) < 4, which is 0x0F0F.
    - P3 = ~P2, which is 0x10F0.
    - P4 = all zeros.
    - P5 = all ones.
    - P6 = 8'hF5 zero-extended, or truncated when DATA_W < 8; 0x00F5 at width 13.
  - Mode 1 (walking one): word k = 1 << k, for k = 0..DATA_W-1. Sequence length is DATA_W.
  - Mode 2 (PRBS7):
    - Polynomial x^7+x^6+1; LFSR advances once per word.
    - Word = 7-bit LFSR state replicated from LSB and truncated to DATA_W.
    - Sequence length is 127. The LFSR reloads 7'h7F at start.
  - Mode 3: reserved, behaves as mode 0.
- End of sequence (last word sent):
  - Sequence counter increments (REPEAT_W bits).
  - If stop is pending, or i_repeat != 0 and the count equals i_repeat: go to DONE. Otherwise index wraps to 0 and the next word has o_frame=1.
  - Continuous mode (i_repeat=0): the counter wraps freely and never terminates the run.
- Stop: i_stop=1 in any RUN cycle sets a sticky pending flag. The current sequence always completes; there is no mid-sequence truncation.
- DATA_W=4 with mode 2: a stop that arrives during the last word of a sequence takes effect at that boundary.
- DONE: lasts one cycle. o_done=1, o_busy=0, o_data=0, o_frame=0. o_strobe holds its last value. Next state is IDLE.
- i_start while in RUN or DONE is ignored.
- i_start and i_stop together in IDLE: the run starts with stop pending, so exactly one sequence is sent.
- Asynchronous reset mid-run returns to IDLE immediately with the reset values above. No o_done pulse.

Optional Feature:
- Macro: MIB_TRAIN_ERRINJ_EN.
- With the macro defined:
  - Adds port i_inject (input, 1 bit).
  - An i_inject pulse arms a flag. The next word sent has bit 0 inverted, then the flag clears.
  - Pulses while the flag is armed merge into one.
  - The flag clears on reset and when leaving RUN.
- Without the macro: the port is absent and words are never altered.

Test Plan:
- Reset, i_en=1, mode 0, repeat 2, pulse start:
  - o_data is 0AAA,1555,0F0F,10F0,0000,1FFF,00F5 twice.
  - o_frame is high on both 0AAA words.
  - 14 strobe toggles.
  - o_done pulses 1 cycle after the last word.
- Mode 1, repeat 1, DATA_W=13: 0001,0002,...,1000 (13 words), then o_done.
- Mode 2, repeat 1: first words follow PRBS7 from seed 7F. Exactly 127 words. The word at index 127 would equal index 0.
- Mode 0, repeat 0, stop asserted mid-sequence (on the third word): the sequence completes through 00F5, then o_done. No further words.
- i_en toggled low for 3 cycles mid-run: o_data and o_strobe frozen, o_frame low, sequence resumes with no words skipped.
- Reset asserted mid-run: all outputs 0 asynchronously, no o_done. With MIB_TRAIN_ERRINJ_EN defined, an inject pulse turns the next 0AAA into 0AAB.
